// File: rtl/sequence_stream_gen.sv
// sequence_stream_gen: serial pattern transmitter.
// Loads a PAT_W-bit pattern on an accepted start and shifts it out MSB first,
// repeat_cnt times, one bit per clk. busy/done report progress.
// Optional feature macro: STREAM_GAP_EN. When it is defined, the gap_len port
// exists and inserts idle-zero cycles between repetitions. When it is not
// defined, repetitions are always back-to-back.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start, out_stream=0
// SEND  | shifting captured pattern out, MSB first
// GAP   | idle-zero cycles between repetitions (STREAM_GAP_EN only)
// DONE  | one-cycle done pulse, start ignored, then back to IDLE

module sequence_stream_gen #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
`ifdef STREAM_GAP_EN
    input  logic [GAP_W-1:0] gap_len,
`endif
    output logic             out_stream,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Parameter sanity: an out-of-range width leaves a visibly named block.
    if (PAT_W < 2) begin : g_bad_pat_w
    end
    if (GAP_W < 1) begin : g_bad_gap_w
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] idx_m1;
    logic [CNT_W-1:0] reps_q, reps_d;
    logic             out_q, out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef STREAM_GAP_EN
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
`endif

    assign idx_m1 = idx_q - IDX_ONE;

    // Next-state, shift-register, counter and output decode.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        idx_d   = idx_q;
        reps_d  = reps_q;
        out_d   = 1'b0;
`ifdef STREAM_GAP_EN
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    pat_d  = pattern;
                    reps_d = repeat_cnt;
`ifdef STREAM_GAP_EN
                    gap_d  = gap_len;
`endif
                    if (repeat_cnt == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = SEND;
                        out_d   = pattern[PAT_W-1];
                        idx_d   = IDX_MSB;
                    end
                end
            end
            SEND: begin
                if (idx_q != '0) begin
                    idx_d = idx_m1;
                    out_d = pat_q[idx_m1];
                end else begin
                    // Bit 0 has just been on the line: one repetition complete.
                    reps_d = reps_q - CNT_ONE;
                    if (reps_q == CNT_ONE) begin
                        state_d = DONE;
`ifdef STREAM_GAP_EN
                    end else if (gap_q != '0) begin
                        state_d   = GAP;
                        gap_cnt_d = gap_q;
`endif
                    end else begin
                        out_d = pat_q[PAT_W-1];
                        idx_d = IDX_MSB;
                    end
                end
            end
            GAP: begin
`ifdef STREAM_GAP_EN
                if (gap_cnt_q == GAP_W'(1)) begin
                    state_d   = SEND;
                    gap_cnt_d = '0;
                    out_d     = pat_q[PAT_W-1];
                    idx_d     = IDX_MSB;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SEND) || (state_d == GAP);
        done_d = (state_d == DONE);
    end

    // State register plus registered outputs; reset abandons any run in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            idx_q   <= '0;
            reps_q  <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            idx_q   <= idx_d;
            reps_q  <= reps_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef STREAM_GAP_EN
    // Captured gap length and the gap down-counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap_q     <= '0;
            gap_cnt_q <= '0;
        end else begin
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end
`endif

    assign out_stream = out_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign state      = state_q;

endmodule

// File: tb/tb_sequence_stream_gen.sv
// Self-checking bench for sequence_stream_gen: table of directed transfers
// plus hand-written sequences for reset mid-run, start in DONE, max repeat
// count and (with STREAM_GAP_EN) gap insertion.

module tb_sequence_stream_gen;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] pattern;
    logic [7:0] repeat_cnt;
    logic [3:0] gap_len;
    logic       out_stream;
    logic       busy;
    logic       done;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    sequence_stream_gen #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pattern    (pattern),
        .repeat_cnt (repeat_cnt),
`ifdef STREAM_GAP_EN
        .gap_len    (gap_len),
`endif
        .out_stream (out_stream),
        .busy       (busy),
        .done       (done),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  pat;
        logic [7:0]  reps;
        logic [31:0] bits;
        int          len;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full transfer; bits holds the expected stream with its first bit at bits[len-1].
    task automatic run_tx(input logic [3:0] pat, input logic [7:0] reps,
                          input logic [31:0] bits, input int len);
        @(posedge clk);
        #1 pattern = pat; repeat_cnt = reps; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            check("tx_bit", 32'(out_stream), 32'(bits[len-1-i]));
            check("tx_busy", 32'(busy), 32'd1);
            check("tx_state", 32'(state), 32'd1);
            check("tx_done_low", 32'(done), 32'd0);
            // Inputs wiggled mid-run must not disturb the captured copies.
            if (i == 1) begin
                start = 1'b1; pattern = ~pat; repeat_cnt = reps + 8'd3;
            end
            if (i == 2) start = 1'b0;
        end
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd1);
        check("done_state", 32'(state), 32'd3);
        check("done_busy", 32'(busy), 32'd0);
        check("done_out", 32'(out_stream), 32'd0);
        @(negedge clk);
        check("after_state", 32'(state), 32'd0);
        check("after_done", 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        int ones;

        vecs[0] = '{4'b1011, 8'd1, 32'b1011, 4};
        vecs[1] = '{4'b1011, 8'd2, 32'b1011_1011, 8};
        vecs[2] = '{4'b1111, 8'd0, 32'b0, 0};
        vecs[3] = '{4'b0110, 8'd3, 32'b0110_0110_0110, 12};
        vecs[4] = '{4'b0001, 8'd2, 32'b0001_0001, 8};
        vecs[5] = '{4'b1000, 8'd1, 32'b1000, 4};
        vecs[6] = '{4'b1111, 8'd1, 32'b1111, 4};

        reset = 1'b1; start = 1'b0; pattern = '0; repeat_cnt = '0; gap_len = '0;
        #100 reset = 1'b0;
        @(negedge clk);
        check("rst_out", 32'(out_stream), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_state", 32'(state), 32'd0);

        for (int v = 0; v < 7; v++)
            run_tx(vecs[v].pat, vecs[v].reps, vecs[v].bits, vecs[v].len);

        // start held during DONE must be ignored.
        @(posedge clk);
        #1 pattern = 4'b1011; repeat_cnt = 8'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        @(negedge clk);
        check("dig_done", 32'(done), 32'd1);
        start = 1'b1;
        @(negedge clk);
        check("dig_idle", 32'(state), 32'd0);
        start = 1'b0;
        @(negedge clk);
        check("dig_stay_idle", 32'(state), 32'd0);
        check("dig_no_busy", 32'(busy), 32'd0);

        // Reset asserted during the 2nd bit of a 3-repetition run.
        @(posedge clk);
        #1 pattern = 4'b1111; repeat_cnt = 8'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #2;
        check("mid_pre_out", 32'(out_stream), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_out", 32'(out_stream), 32'd0);
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_post_state", 32'(state), 32'd0);
        run_tx(4'b1011, 8'd1, 32'b1011, 4);

        // Maximum repeat count, no wrap.
        @(posedge clk);
        #1 pattern = 4'b1100; repeat_cnt = 8'd255; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0; ones = 0;
        while (n < 2000) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            ones += int'(out_stream);
        end
        check("max_len", 32'(n), 32'd1020);
        check("max_ones", 32'(ones), 32'd510);
        check("max_done", 32'(done), 32'd1);

`ifdef STREAM_GAP_EN
        begin
            logic [10:0] gbits;
            gbits = 11'b1001_000_1001;
            @(posedge clk);
            #1 pattern = 4'b1001; repeat_cnt = 8'd2; gap_len = 4'd3; start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            for (int i = 0; i < 11; i++) begin
                @(negedge clk);
                check("gap_bit", 32'(out_stream), 32'(gbits[10-i]));
                check("gap_state", 32'(state), (i >= 4 && i < 7) ? 32'd2 : 32'd1);
                check("gap_busy", 32'(busy), 32'd1);
            end
            @(negedge clk);
            check("gap_done", 32'(done), 32'd1);
            check("gap_done_out", 32'(out_stream), 32'd0);
            gap_len = 4'd0;
        end
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
